// File: rtl/spi_regfile.sv
// spi_regfile: SPI mode-0 (CPOL=0, CPHA=0) peripheral register file.
// Frames are MSB first: R/W bit (1 = write), address, data. Writes land in a
// NUM_REGS x DATA_WIDTH register array after the frame is validated. Reads
// shift the addressed register out on sdo during the data field.
module spi_regfile #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 7,
  parameter int NUM_REGS    = 5,
  parameter int SYNC_STAGES = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           sclk,
  input  logic                           sdi,
  input  logic                           cs,
  output logic                           sdo,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs,
  output logic                           wr_stb,
  output logic [ADDR_WIDTH-1:0]          wr_addr,
  output logic                           frame_err
);

  localparam int FRAME_LEN = 1 + ADDR_WIDTH + DATA_WIDTH;
  // Wide enough to hold FRAME_LEN+1 so an overlong frame stays distinguishable.
  localparam int CNT_WIDTH = $clog2(FRAME_LEN + 2);

  localparam logic [CNT_WIDTH-1:0]  CNT_HDR   = CNT_WIDTH'(1 + ADDR_WIDTH);
  localparam logic [CNT_WIDTH-1:0]  CNT_FULL  = CNT_WIDTH'(FRAME_LEN);
  localparam logic [CNT_WIDTH-1:0]  CNT_SAT   = CNT_WIDTH'(FRAME_LEN + 1);
  localparam logic [ADDR_WIDTH:0]   REG_LIMIT = (ADDR_WIDTH + 1)'(NUM_REGS);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
  localparam logic [1:0] ST_CHECK  = 2'd2;
  localparam logic [1:0] ST_COMMIT = 2'd3;

  logic [1:0]             state;

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] sdi_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic                   sclk_prev;
  logic                   cs_prev;
  logic                   sclk_s;
  logic                   sdi_s;
  logic                   cs_s;
  logic                   sclk_rise;
  logic                   sclk_fall;
  logic                   cs_rise;

  logic [FRAME_LEN-1:0]   shift_reg;
  logic [CNT_WIDTH-1:0]   count;
  logic [DATA_WIDTH-1:0]  tx_reg;
  logic                   tx_loaded;

  logic [DATA_WIDTH-1:0]  mem [NUM_REGS];

  logic                   frame_rw;
  logic [ADDR_WIDTH-1:0]  frame_addr;
  logic [DATA_WIDTH-1:0]  frame_data;
  logic                   frame_full;
  logic                   addr_ok;
  logic                   hdr_rw;
  logic [ADDR_WIDTH-1:0]  hdr_addr;
  logic [DATA_WIDTH-1:0]  rd_data;

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign sdi_s     = sdi_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev;
  assign sclk_fall = ~sclk_s & sclk_prev;
  assign cs_rise   = cs_s & ~cs_prev;

  // Full-frame field view, used once the frame has ended.
  assign frame_rw   = shift_reg[FRAME_LEN-1];
  assign frame_addr = shift_reg[FRAME_LEN-2 -: ADDR_WIDTH];
  assign frame_data = shift_reg[DATA_WIDTH-1:0];
  assign frame_full = (count == CNT_FULL);
  assign addr_ok    = ({1'b0, frame_addr} < REG_LIMIT);

  // Header view: valid when exactly 1+ADDR_WIDTH bits have been shifted in.
  assign hdr_rw   = shift_reg[ADDR_WIDTH];
  assign hdr_addr = shift_reg[ADDR_WIDTH-1:0];

  // Synchronise the SPI pins and keep one-cycle history for edge detection.
  // cs resets to its inactive (high) level so no false frame start is seen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= '0;
      sdi_sync  <= '0;
      cs_sync   <= '1;
      sclk_prev <= 1'b0;
      cs_prev   <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      sdi_sync  <= {sdi_sync[SYNC_STAGES-2:0], sdi};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
      sclk_prev <= sclk_s;
      cs_prev   <= cs_s;
    end
  end

  // Read mux; out-of-range addresses read as zero.
  always_comb begin
    rd_data = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (hdr_addr == ADDR_WIDTH'(i)) rd_data = mem[i];
    end
  end

  // Frame FSM: shift in bits, shift out read data, validate and commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      shift_reg <= '0;
      count     <= '0;
      tx_reg    <= '0;
      tx_loaded <= 1'b0;
      sdo       <= 1'b0;
      wr_stb    <= 1'b0;
      wr_addr   <= '0;
      frame_err <= 1'b0;
    end else begin
      wr_stb    <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          sdo       <= 1'b0;
          tx_loaded <= 1'b0;
          // Level test also picks up a cs fall that arrived during CHECK/COMMIT.
          if (!cs_s) begin
            state     <= ST_SHIFT;
            shift_reg <= '0;
            count     <= '0;
          end
        end
        ST_SHIFT: begin
          if (cs_rise) begin
            state <= ST_CHECK;
            sdo   <= 1'b0;
          end else begin
            if (sclk_rise) begin
              shift_reg <= {shift_reg[FRAME_LEN-2:0], sdi_s};
              if (count != CNT_SAT) count <= count + 1'b1;
            end else if (sclk_fall && tx_loaded) begin
              sdo    <= tx_reg[DATA_WIDTH-1];
              tx_reg <= tx_reg << 1;
            end
            if (!tx_loaded && count == CNT_HDR && !hdr_rw) begin
              tx_reg    <= rd_data;
              tx_loaded <= 1'b1;
            end
          end
        end
        ST_CHECK: begin
          if (frame_full && frame_rw && addr_ok) begin
            state <= ST_COMMIT;
          end else begin
            state <= ST_IDLE;
            if (!(frame_full && !frame_rw)) frame_err <= 1'b1;
          end
        end
        ST_COMMIT: begin
          wr_stb  <= 1'b1;
          wr_addr <= frame_addr;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Register array; written only from COMMIT, so partial frames never land.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) mem[i] <= '0;
    end else if (state == ST_COMMIT) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (frame_addr == ADDR_WIDTH'(i)) mem[i] <= frame_data;
      end
    end
  end

  // Flatten the register array onto the regs bus.
  always_comb begin
    regs = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      regs[i*DATA_WIDTH +: DATA_WIDTH] = mem[i];
    end
  end

endmodule

// File: tb/tb_spi_regfile.sv
// Scoreboard bench for spi_regfile: one default instance, one 16-bit/4-bit/16-reg instance.
module tb_spi_regfile;

  localparam int HALF   = 8;
  localparam int K_WR   = 0;
  localparam int K_ERR  = 1;
  localparam int K_RD   = 2;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         sclk  = 1'b0;
  logic         sdi   = 1'b0;
  logic         cs0   = 1'b1;
  logic         cs1   = 1'b1;

  logic         sdo0, sdo1;
  logic [39:0]  regs0;
  logic [255:0] regs1;
  logic         wr_stb0, wr_stb1;
  logic [6:0]   wr_addr0;
  logic [3:0]   wr_addr1;
  logic         frame_err0, frame_err1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int kind;
    int addr;
    int data;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  logic [31:0] cap0 = '0, cap1 = '0;
  int          n0 = 0, n1 = 0;
  logic        first0 = 1'b0, first1 = 1'b0;

  spi_regfile dut0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .sclk      (sclk),
    .sdi       (sdi),
    .cs        (cs0),
    .sdo       (sdo0),
    .regs      (regs0),
    .wr_stb    (wr_stb0),
    .wr_addr   (wr_addr0),
    .frame_err (frame_err0)
  );

  spi_regfile #(
    .DATA_WIDTH  (16),
    .ADDR_WIDTH  (4),
    .NUM_REGS    (16),
    .SYNC_STAGES (2)
  ) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .sclk      (sclk),
    .sdi       (sdi),
    .cs        (cs1),
    .sdo       (sdo1),
    .regs      (regs1),
    .wr_stb    (wr_stb1),
    .wr_addr   (wr_addr1),
    .frame_err (frame_err1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input int dut, input int kind, input int addr, input int data);
    exp_t e;
    e.kind = kind;
    e.addr = addr;
    e.data = data;
    if (dut == 0) q0.push_back(e);
    else          q1.push_back(e);
  endtask

  // Pops the oldest expectation for a DUT and compares it with an observed event.
  task automatic mon(input int dut, input int kind, input int addr, input int data);
    exp_t e;
    int   qs;
    qs = (dut == 0) ? q0.size() : q1.size();
    if (qs == 0) begin
      tests++;
      fails++;
      $display("FAIL d%0d_unexpected: got event kind %0d addr %0d data %0h, expected none",
               dut, kind, addr, data);
    end else begin
      if (dut == 0) e = q0.pop_front();
      else          e = q1.pop_front();
      chk($sformatf("d%0d_kind", dut), 256'(kind), 256'(e.kind));
      if (e.kind == K_WR)
        chk($sformatf("d%0d_wr_addr", dut), 256'(addr), 256'(e.addr));
      if (e.kind != K_ERR)
        chk($sformatf("d%0d_data", dut), 256'(data), 256'(e.data));
    end
  endtask

  // Strobe monitors, sampled on the inactive clock edge.
  always @(negedge clk) begin
    if (wr_stb0)    mon(0, K_WR, int'(wr_addr0), int'(regs0[8*int'(wr_addr0) +: 8]));
    if (frame_err0) mon(0, K_ERR, 0, 0);
    if (wr_stb1)    mon(1, K_WR, int'(wr_addr1), int'(regs1[16*int'(wr_addr1) +: 16]));
    if (frame_err1) mon(1, K_ERR, 0, 0);
  end

  // Bus monitors: sample sdo as the master would, present read data at cs rise.
  always @(posedge sclk) begin
    if (!cs0) begin
      if (n0 == 0) first0 = sdi;
      cap0 = {cap0[30:0], sdo0};
      n0++;
    end
    if (!cs1) begin
      if (n1 == 0) first1 = sdi;
      cap1 = {cap1[30:0], sdo1};
      n1++;
    end
  end

  always @(posedge cs0) begin
    if (n0 > 0 && !first0) mon(0, K_RD, 0, int'(cap0[7:0]));
    n0 = 0;
  end

  always @(posedge cs1) begin
    if (n1 > 0 && !first1) mon(1, K_RD, 0, int'(cap1[15:0]));
    n1 = 0;
  end

  task automatic half_wait();
    repeat (HALF) @(negedge clk);
  endtask

  task automatic spi_begin(input int dut);
    if (dut == 0) cs0 = 1'b0;
    else          cs1 = 1'b0;
    half_wait();
  endtask

  task automatic spi_bits(input int n, input logic [31:0] bits);
    for (int i = n - 1; i >= 0; i--) begin
      sdi = bits[i];
      half_wait();
      sclk = 1'b1;
      half_wait();
      sclk = 1'b0;
    end
  endtask

  task automatic spi_end();
    half_wait();
    cs0 = 1'b1;
    cs1 = 1'b1;
    sdi = 1'b0;
    repeat (14) @(negedge clk);
  endtask

  task automatic spi_frame(input int dut, input int n, input logic [31:0] bits);
    spi_begin(dut);
    spi_bits(n, bits);
    spi_end();
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    chk("reset_regs0",   256'(regs0), 256'(0));
    chk("reset_regs1",   regs1, 256'(0));
    chk("reset_sdo0",    256'(sdo0), 256'(0));
    chk("reset_wr_stb0", 256'(wr_stb0), 256'(0));
    chk("reset_wr_addr0", 256'(wr_addr0), 256'(0));
    chk("reset_ferr0",   256'(frame_err0), 256'(0));

    // write 0xA5 to addr 3
    push(0, K_WR, 3, 'hA5);
    spi_frame(0, 16, 32'h83A5);
    chk("regs_w3", 256'(regs0), 256'(40'h00_A5_00_00_00));

    // write 0x3C to addr 1
    push(0, K_WR, 1, 'h3C);
    spi_frame(0, 16, 32'h813C);
    chk("regs_w1", 256'(regs0), 256'(40'h00_A5_00_3C_00));

    // read addr 1
    push(0, K_RD, 0, 'h3C);
    spi_frame(0, 16, 32'h0100);
    chk("regs_after_rd1", 256'(regs0), 256'(40'h00_A5_00_3C_00));
    chk("wr_addr_held",   256'(wr_addr0), 256'(1));
    chk("sdo_idle",       256'(sdo0), 256'(0));

    // out-of-range write addr 5
    push(0, K_ERR, 0, 0);
    spi_frame(0, 16, 32'h8577);
    chk("regs_after_w5", 256'(regs0), 256'(40'h00_A5_00_3C_00));

    // read of unimplemented addr 6 returns zero
    push(0, K_RD, 0, 'h00);
    spi_frame(0, 16, 32'h0600);

    // short and long write frames
    push(0, K_ERR, 0, 0);
    spi_frame(0, 15, 32'h412A);
    push(0, K_ERR, 0, 0);
    spi_frame(0, 17, 32'h104AB);
    chk("regs_after_badlen", 256'(regs0), 256'(40'h00_A5_00_3C_00));

    // reset after 10 bits of a write to addr 0
    spi_begin(0);
    spi_bits(10, 32'h200);
    half_wait();
    rst_n = 1'b0;
    cs0   = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (14) @(negedge clk);
    chk("regs_after_rst",   256'(regs0), 256'(0));
    chk("wr_addr_after_rst", 256'(wr_addr0), 256'(0));

    push(0, K_WR, 0, 'h11);
    spi_frame(0, 16, 32'h8011);
    chk("regs_w0", 256'(regs0), 256'(40'h00_00_00_00_11));

    // wide instance: write 0xBEEF to addr 15, then read back
    push(1, K_WR, 15, 'hBEEF);
    spi_frame(1, 21, 32'h1FBEEF);
    chk("d1_top_word", 256'(regs1[255:240]), 256'(16'hBEEF));
    chk("d1_low_words", 256'(regs1[239:0]), 256'(0));

    push(1, K_RD, 0, 'hBEEF);
    spi_frame(1, 21, 32'h0F0000);
    chk("d1_top_after_rd", 256'(regs1[255:240]), 256'(16'hBEEF));

    repeat (20) @(negedge clk);
    chk("q0_drained", 256'(q0.size()), 256'(0));
    chk("q1_drained", 256'(q1.size()), 256'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
